// File: rtl/uart_controller.sv
// uart_controller: 8N1 UART with independent TX and oversampled RX, mode-gated start.
// Ports:
//   clk, reset_n          - system clock, asynchronous active-low reset
//   mode[1:0]             - 00 TX only, 01 RX only, 10 TX+RX, 11 both disabled
//   tx_data, tx_start     - byte and request; latched when TX is idle and enabled
//   tx_busy               - high while a frame is in flight (or being requested)
//   uart_tx               - serial output, idles high
//   uart_rx               - asynchronous serial input
//   rx_data, rx_valid     - last good byte and its level flag
module uart_controller #(
  parameter int CLOCK_RATE    = 25000000,
  parameter int BAUD_RATE     = 115200,
  parameter int RX_OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] mode,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] rx_data,
  output logic       rx_valid
);
  localparam int TX_DIV = CLOCK_RATE / BAUD_RATE;
  localparam int RX_DIV = CLOCK_RATE / (BAUD_RATE * RX_OVERSAMPLE);
  localparam int TXW    = $clog2(TX_DIV + 1);
  localparam int RXW    = $clog2(RX_DIV + 1);
  localparam int OSW    = $clog2(RX_OVERSAMPLE + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic w_tx_en, w_rx_en;
  assign w_tx_en = ~mode[0];
  assign w_rx_en = ^mode;

  state_t         r_tx_state, w_tx_next;
  logic [TXW-1:0] r_tx_cnt;
  logic [2:0]     r_tx_idx;
  logic [7:0]     r_tx_shift;
  logic           w_tx_go, w_tx_bit_end;

  assign w_tx_go      = (r_tx_state == IDLE) && tx_start && w_tx_en;
  assign w_tx_bit_end = r_tx_cnt == TXW'(TX_DIV - 1);
  assign tx_busy      = (r_tx_state != IDLE) || w_tx_go;
  // Output decoded from state so an asynchronous reset forces the line high at once.
  assign uart_tx      = (r_tx_state == START) ? 1'b0 :
                        (r_tx_state == DATA)  ? r_tx_shift[0] : 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_tx_state <= IDLE;
    else          r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      IDLE:    w_tx_next = w_tx_go ? START : IDLE;
      START:   w_tx_next = w_tx_bit_end ? DATA : START;
      DATA:    w_tx_next = (w_tx_bit_end && r_tx_idx == 3'd7) ? STOP : DATA;
      STOP:    w_tx_next = w_tx_bit_end ? IDLE : STOP;
      default: w_tx_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
    end else if (r_tx_state == IDLE) begin
      r_tx_cnt <= '0;
      r_tx_idx <= '0;
      if (w_tx_go) r_tx_shift <= tx_data;
    end else if (w_tx_bit_end) begin
      r_tx_cnt <= '0;
      if (r_tx_state == DATA) begin
        r_tx_shift <= r_tx_shift >> 1;
        r_tx_idx   <= r_tx_idx + 3'd1;
      end
    end else begin
      r_tx_cnt <= r_tx_cnt + TXW'(1);
    end
  end

  logic r_rx_meta, r_rx_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  state_t         r_rx_state, w_rx_next;
  logic [RXW-1:0] r_tick_cnt;
  logic [OSW-1:0] r_rx_os;
  logic [2:0]     r_rx_idx;
  logic [7:0]     r_rx_shift, r_rx_data;
  logic           r_rx_valid;
  logic           w_tick, w_half, w_full, w_os_wrap;

  assign w_tick    = r_tick_cnt == RXW'(RX_DIV - 1);
  assign w_half    = r_rx_os == OSW'(RX_OVERSAMPLE / 2 - 1);
  assign w_full    = r_rx_os == OSW'(RX_OVERSAMPLE - 1);
  // START waits half a bit to land mid-bit; every later sample is a full bit apart.
  assign w_os_wrap = (r_rx_state == START) ? w_half : w_full;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rx_state <= IDLE;
    else          r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      IDLE:    w_rx_next = (w_rx_en && !r_rx_sync) ? START : IDLE;
      START:   w_rx_next = (w_tick && w_half) ? (r_rx_sync ? IDLE : DATA) : START;
      DATA:    w_rx_next = (w_tick && w_full && r_rx_idx == 3'd7) ? STOP : DATA;
      STOP:    w_rx_next = (w_tick && w_full) ? IDLE : STOP;
      default: w_rx_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt <= '0;
      r_rx_os    <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else if (r_rx_state == IDLE) begin
      // Tick phase restarts at the detected edge so sampling is centred on each bit.
      r_tick_cnt <= '0;
      r_rx_os    <= '0;
      r_rx_idx   <= '0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + RXW'(1);
      if (w_tick) begin
        r_rx_os <= w_os_wrap ? '0 : r_rx_os + OSW'(1);
        if (r_rx_state == START && w_half && !r_rx_sync) r_rx_valid <= 1'b0;
        if (r_rx_state == DATA && w_full) begin
          r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
          r_rx_idx   <= r_rx_idx + 3'd1;
        end
        if (r_rx_state == STOP && w_full && r_rx_sync) begin
          r_rx_data  <= r_rx_shift;
          r_rx_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_controller.sv
// tb_uart_controller: directed checks of TX timing, loopback, RX errors and reset.
module tb_uart_controller;
  localparam int BIT   = 217;
  localparam int FRAME = 10 * BIT;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] mode;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       uart_tx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_drv, loop, rx_line;
  int         checks = 0;
  int         errors = 0;

  assign rx_line = loop ? uart_tx : rx_drv;

  uart_controller dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .uart_rx(rx_line),
    .uart_tx(uart_tx), .rx_data(rx_data), .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic [1:0] mid_mode,
                      output int busy_cnt, output logic [9:0] wave, output logic busy_after,
                      output logic rxv_low, output logic rxv_end, output logic [7:0] rxd_end);
    busy_cnt = 0; wave = '0; busy_after = 1'b1; rxv_low = 1'b0; rxv_end = 1'b0; rxd_end = '0;
    @(negedge clk);
    tx_data = b; tx_start = 1'b1;
    #1 check("busy_on_request", tx_busy, 1);
    @(posedge clk);
    #1 tx_start = 1'b0;
    for (int n = 0; n <= FRAME; n++) begin
      @(negedge clk);
      if (n == 1000) mode = mid_mode;
      if (n < FRAME) begin
        if (tx_busy) busy_cnt++;
        if (!rx_valid) rxv_low = 1'b1;
        if (n % BIT == BIT / 2) wave[n / BIT] = uart_tx;
        if (n == FRAME - 1) begin
          rxv_end = rx_valid;
          rxd_end = rx_data;
        end
      end else begin
        busy_after = tx_busy;
      end
    end
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop_bit, input int stop_len);
    rx_drv = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      wait_cyc(BIT);
    end
    rx_drv = stop_bit;
    wait_cyc(stop_len);
    rx_drv = 1'b1;
    wait_cyc(BIT);
  endtask

  task automatic tx_disabled(input logic [1:0] m, input string tag);
    int bad;
    bad = 0;
    mode = m;
    @(negedge clk);
    tx_data = 8'hFF; tx_start = 1'b1;
    #1 check({tag, "_busy_req"}, tx_busy, 0);
    @(posedge clk);
    #1 tx_start = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (tx_busy || !uart_tx) bad++;
    end
    check({tag, "_line_idle"}, bad, 0);
  endtask

  int         bc;
  logic [9:0] wv;
  logic       ba, rl, re;
  logic [7:0] rd;

  initial begin
    reset_n = 1'b0; mode = 2'b11; tx_data = '0; tx_start = 1'b0; rx_drv = 1'b1; loop = 1'b0;
    wait_cyc(5);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    @(negedge clk) reset_n = 1'b1;
    wait_cyc(5);

    mode = 2'b00; loop = 1'b1;
    send(8'h41, 2'b00, bc, wv, ba, rl, re, rd);
    check("tx41_busy_len", bc, FRAME);
    check("tx41_wave", wv, {1'b1, 8'h41, 1'b0});
    check("tx41_busy_fall", ba, 0);
    check("tx41_rx_off", re, 0);
    wait_cyc(300);
    check("tx41_rx_valid", rx_valid, 0);

    tx_disabled(2'b01, "mode01");
    tx_disabled(2'b11, "mode11");

    mode = 2'b10;
    send(8'h42, 2'b10, bc, wv, ba, rl, re, rd);
    check("lb42_valid", re, 1);
    check("lb42_data", rd, 8'h42);
    mode = 2'b01; loop = 1'b0;
    wait_cyc(500);
    check("hold42_valid", rx_valid, 1);
    check("hold42_data", rx_data, 8'h42);

    mode = 2'b10; loop = 1'b1;
    send(8'h43, 2'b10, bc, wv, ba, rl, re, rd);
    check("lb43_valid_dropped", rl, 1);
    check("lb43_valid", re, 1);
    check("lb43_data", rd, 8'h43);
    check("lb43_busy_len", bc, FRAME);
    check("lb43_wave", wv, {1'b1, 8'h43, 1'b0});

    send(8'h3C, 2'b11, bc, wv, ba, rl, re, rd);
    check("mid_off_busy_len", bc, FRAME);
    check("mid_off_wave", wv, {1'b1, 8'h3C, 1'b0});
    check("mid_off_busy_fall", ba, 0);
    check("mid_off_rx_data", rd, 8'h3C);

    mode = 2'b01; loop = 1'b0;
    wait_cyc(50);
    rx_drv = 1'b0;
    wait_cyc(39);
    rx_drv = 1'b1;
    wait_cyc(400);
    check("false_start_valid", rx_valid, 1);
    check("false_start_data", rx_data, 8'h3C);

    drive_rx(8'h5A, 1'b0, 60);
    check("frame_err_valid", rx_valid, 0);
    check("frame_err_data", rx_data, 8'h3C);
    drive_rx(8'hA5, 1'b1, BIT);
    check("good_a5_valid", rx_valid, 1);
    check("good_a5_data", rx_data, 8'hA5);

    mode = 2'b00;
    @(negedge clk);
    tx_data = 8'h00; tx_start = 1'b1;
    @(posedge clk);
    #1 tx_start = 1'b0;
    wait_cyc(300);
    check("pre_rst_mid_frame", uart_tx, 0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_uart_tx", uart_tx, 1);
    check("async_rst_busy", tx_busy, 0);
    check("async_rst_rx_valid", rx_valid, 0);
    check("async_rst_rx_data", rx_data, 0);
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(300);
    check("post_rst_idle", uart_tx, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
